// File: rtl/bounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bounce_pkg
// Description : Shared definitions for the contact-bounce emulator:
//               FSM state encoding, LFSR feedback taps and timer width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bounce_pkg;

  // Emulator state: waiting for a level change, or playing out a sequence
  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_BOUNCE = 1'b1
  } state_t;

  // Galois feedback mask (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Segment timer width; wide enough for MIN_LEN plus a full 16-bit extra
  localparam int TIMER_W = 20;

endpackage : bounce_pkg
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Galois LFSR, free running. Loaded with the seed while
//               reset is held; a zero seed would lock the register at zero,
//               so it is replaced by 16'h0001.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset (loads seed)
//               seed  - reset value
//               q     - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
  import bounce_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic [15:0] w_seed_eff;

  assign w_seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= w_seed_eff;
    end else if (r_q[0]) begin
      r_q <= (r_q >> 1) ^ LFSR_TAPS;
    end else begin
      r_q <= r_q >> 1;
    end
  end

  assign q = r_q;

endmodule : lfsr16
`default_nettype wire

// File: rtl/bounce_gen.sv
`default_nettype none
// ============================================================================
// Module      : bounce_gen
// Description : Contact-bounce emulator. Turns a clean level command into a
//               bouncy waveform made of BOUNCE_CNT+1 segments of
//               pseudo-random length, then settles on the commanded level.
// Ports       : clk       - system clock
//               reset     - synchronous active-high reset
//               level     - clean commanded level
//               bounce_en - 1: emulate bounce, 0: noisy follows level
//               noisy     - emulated switch output (registered)
//               busy      - high while a bounce sequence is in progress
//               done      - one-cycle pulse when the sequence settles
// Revision    : 1.0 - initial release
// ============================================================================
module bounce_gen
  import bounce_pkg::*;
#(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          BOUNCE_CNT = 6,
  parameter int          MIN_LEN    = 2000,
  parameter logic [15:0] LEN_MASK   = 16'h3FFF
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic bounce_en,
  output logic noisy,
  output logic busy,
  output logic done
);

  localparam logic [3:0]         C_BOUNCE_CNT = 4'(BOUNCE_CNT);
  localparam logic [TIMER_W-1:0] C_MIN_LEN    = TIMER_W'(MIN_LEN);
  localparam logic [TIMER_W-1:0] C_ONE        = TIMER_W'(1);

  state_t               r_state,  w_state_nxt;
  logic                 r_noisy,  w_noisy_nxt;
  logic                 r_target, w_target_nxt;
  logic                 r_done,   w_done_nxt;
  logic [3:0]           r_left,   w_left_nxt;
  logic [TIMER_W-1:0]   r_timer,  w_timer_nxt;

  logic [15:0]          w_lfsr;
  logic [TIMER_W-1:0]   w_seg_last;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (w_lfsr)
  );

  // Timer reload value: segment length minus one, so that counting down to
  // zero and acting on the following edge gives exactly L cycles.
  assign w_seg_last = C_MIN_LEN + TIMER_W'(w_lfsr & LEN_MASK) - C_ONE;

  always_comb begin
    w_state_nxt  = r_state;
    w_noisy_nxt  = r_noisy;
    w_target_nxt = r_target;
    w_done_nxt   = 1'b0;
    w_left_nxt   = r_left;
    w_timer_nxt  = r_timer;

    case (r_state)
      S_IDLE: begin
        if (!bounce_en) begin
          w_noisy_nxt = level;
        end else if (level != r_noisy) begin
          // First segment already shows the new level
          w_target_nxt = level;
          w_noisy_nxt  = level;
          w_left_nxt   = C_BOUNCE_CNT;
          w_timer_nxt  = w_seg_last;
          w_state_nxt  = S_BOUNCE;
        end
      end

      S_BOUNCE: begin
        if (r_timer == '0) begin
          if (r_left != 4'd0) begin
            w_noisy_nxt = ~r_noisy;
            w_left_nxt  = r_left - 4'd1;
            w_timer_nxt = w_seg_last;
          end else begin
            // Forced to target so odd toggle counts still settle correctly
            w_noisy_nxt = r_target;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer - C_ONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_noisy  <= 1'b0;
      r_target <= 1'b0;
      r_done   <= 1'b0;
      r_left   <= 4'd0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_noisy  <= w_noisy_nxt;
      r_target <= w_target_nxt;
      r_done   <= w_done_nxt;
      r_left   <= w_left_nxt;
      r_timer  <= w_timer_nxt;
    end
  end

  assign noisy = r_noisy;
  assign busy  = (r_state == S_BOUNCE);
  assign done  = r_done;

endmodule : bounce_gen
`default_nettype wire

// File: tb/tb_bounce_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_bounce_gen
// Description : Self-checking bench for bounce_gen. A predictor expands each
//               accepted level change into its full list of expected noisy
//               edges and the done instant; a negedge monitor compares what
//               the DUT shows against those queues and against the expected
//               busy window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bounce_gen;

  localparam logic [15:0] TB_SEED     = 16'h0000;  // exercises zero-seed substitution
  localparam logic [15:0] TB_SEED_EFF = 16'h0001;
  localparam int          TB_BOUNCE   = 3;
  localparam int          TB_MIN_LEN  = 4;
  localparam logic [15:0] TB_MASK     = 16'h000F;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic level     = 1'b1;
  logic bounce_en = 1'b1;
  logic noisy, busy, done;

  always #5 clk = ~clk;

  bounce_gen #(
    .SEED       (TB_SEED),
    .BOUNCE_CNT (TB_BOUNCE),
    .MIN_LEN    (TB_MIN_LEN),
    .LEN_MASK   (TB_MASK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .level     (level),
    .bounce_en (bounce_en),
    .noisy     (noisy),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int cyc;
    bit val;
  } edge_t;

  edge_t       edge_q[$];
  int          done_q[$];

  int          cyc        = 0;
  int          n_checks   = 0;
  int          n_pass     = 0;
  logic [15:0] m_lfsr     = TB_SEED_EFF;
  bit          m_noisy    = 1'b0;
  int          m_start    = 0;
  int          m_last_end = -1;
  logic        prev_noisy = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Predictor: on each edge decide whether a new sequence begins, and if so
  // lay out its whole waveform in absolute cycle numbers.
  always @(posedge clk) begin : predictor
    logic [15:0] x;
    int          stamp;
    int          len;
    bit          cur, nv;
    cyc = cyc + 1;
    if (reset) begin
      edge_q.delete();
      done_q.delete();
      m_noisy    = 1'b0;
      m_last_end = -1;
      m_lfsr     = TB_SEED_EFF;
    end else begin
      if (cyc > m_last_end) begin
        if (!bounce_en) begin
          if (level != m_noisy) edge_q.push_back('{cyc, level});
          m_noisy = level;
        end else if (level != m_noisy) begin
          edge_q.push_back('{cyc, level});
          stamp = cyc;
          x     = m_lfsr;
          cur   = level;
          for (int k = 0; k <= TB_BOUNCE; k++) begin
            len   = TB_MIN_LEN + int'(x & TB_MASK);
            stamp = stamp + len;
            for (int s = 0; s < len; s++) x = lfsr_step(x);
            nv = (k < TB_BOUNCE) ? ~cur : level;
            if (nv != cur) edge_q.push_back('{stamp, nv});
            cur = nv;
          end
          done_q.push_back(stamp);
          m_start    = cyc;
          m_last_end = stamp;
          m_noisy    = level;
        end
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the predicted queues.
  always @(negedge clk) begin : monitor
    edge_t e;
    int    dc;
    if (!reset) begin
      if (edge_q.size() > 0 && edge_q[0].cyc < cyc) begin
        e = edge_q.pop_front();
        check("missed noisy edge", cyc, e.cyc);
      end
      if (noisy !== prev_noisy) begin
        if (edge_q.size() == 0) begin
          check("unexpected noisy edge", 1, 0);
        end else begin
          e = edge_q.pop_front();
          check("noisy edge cycle", cyc, e.cyc);
          check("noisy edge value", int'(noisy), int'(e.val));
        end
      end
      if (done_q.size() > 0 && done_q[0] < cyc) begin
        dc = done_q.pop_front();
        check("missed done", cyc, dc);
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          check("unexpected done", 1, 0);
        end else begin
          dc = done_q.pop_front();
          check("done cycle", cyc, dc);
        end
      end
      check("busy", int'(busy), int'(cyc >= m_start && cyc < m_last_end));
    end
    prev_noisy = noisy;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : driver
    // Reset held with level=1: outputs must sit at zero
    level     = 1'b1;
    bounce_en = 1'b1;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset noisy", int'(noisy), 0);
    check("reset busy",  int'(busy),  0);
    check("reset done",  int'(done),  0);
    @(posedge clk);
    #1 reset = 1'b0;
    // Sequence to level 1 starts immediately; busy on the following edge
    @(posedge clk);
    @(negedge clk);
    check("busy after reset release", int'(busy), 1);
    repeat (120) @(posedge clk);

    // Randomized level changes with a bounce_en=0 follow window and a window
    // of random bounce_en (mid-sequence deassertion must not abort)
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (i >= 1000 && i < 1300) begin
        bounce_en = 1'b0;
        if (i % 3 == 0) level = ~level;
      end else begin
        bounce_en = (i >= 2000 && i < 2200) ? 1'($urandom_range(0, 1)) : 1'b1;
        if ($urandom_range(0, 39) == 0) level = ~level;
      end
    end

    // Reset in the middle of a sequence: no done, everything back to idle
    bounce_en = 1'b1;
    repeat (150) @(posedge clk);
    #1 level = ~noisy;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("busy before mid-sequence reset", int'(busy), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("noisy after mid-sequence reset", int'(noisy), 0);
    check("busy after mid-sequence reset",  int'(busy),  0);
    check("done after mid-sequence reset",  int'(done),  0);
    @(posedge clk);
    #1 reset = 1'b0;

    repeat (200) @(posedge clk);
    @(negedge clk);
    check("edge queue drained", edge_q.size(), 0);
    check("done queue drained", done_q.size(), 0);
    check("final noisy settled", int'(noisy), int'(level));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bounce_gen
`default_nettype wire

// File: doc/bounce_gen.md
# bounce_gen

Synthesizable contact-bounce emulator: the driving end of the debounce interface. It converts a clean level command into a bouncy `noisy` waveform with pseudo-random segment lengths, then settles on the commanded level. The JuegoLED build uses it for on-board and simulation self-test of `debounce`: its `noisy` output connects directly to `debounce.noisy`, and both blocks share `clk`.

## Interface

Parameters:
- `SEED`, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- `BOUNCE_CNT`, 6: number of intermediate toggles before settling (0–15).
- `MIN_LEN`, 2000: minimum segment length in cycles (≥1). At 100 MHz this is 20 µs.
- `LEN_MASK`, 16'h3FFF: AND-mask applied to the LFSR to form the random extra length.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: single system clock (100 MHz).
- `reset`, in, 1: synchronous, active-high reset.
- `level`, in, 1: clean commanded level.
- `bounce_en`, in, 1: 1 = emulate bounce; 0 = `noisy` is a registered copy of `level`.
- `noisy`, out, 1: emulated switch output.
- `busy`, out, 1: high while a bounce sequence is in progress.
- `done`, out, 1: one-cycle pulse on the cycle the sequence settles.

## Operation

- Reset values: `noisy`=0, `busy`=0, `done`=0, state=IDLE, `lfsr`=SEED, `target`=0, `left`=0, `timer`=0.
- LFSR: 16-bit Galois, taps mask 16'hB400. It advances every cycle, except during reset.
- Segment length: L = `MIN_LEN` + (`lfsr` & `LEN_MASK`), using the LFSR value in the cycle the segment is loaded. The timer is 20 bits. The timer is loaded with L−1 and counts down. The segment ends on the cycle after the timer reads 0, so every segment lasts exactly L cycles.
- IDLE:
  - If `bounce_en`=0: `noisy` <= `level`.
  - Else if `level` != `noisy`: `target` <= `level`, `noisy` <= `level`, `left` <= `BOUNCE_CNT`, load timer, go to BOUNCE.
- BOUNCE, when the timer expires:
  - If `left`>0: `noisy` <= ~`noisy`, `left` <= `left`−1, reload timer.
  - If `left`=0: `noisy` <= `target`, `done` <= 1, go to IDLE.
- `busy` is 1 exactly while state=BOUNCE.
- Changes on `level` during BOUNCE are ignored. They are re-evaluated in IDLE on the next cycle.
  - Consequence: a level that returns to `target` mid-sequence produces no new sequence.
- `bounce_en` is sampled only in IDLE. Deasserting it mid-sequence does not abort the sequence.
- Odd `BOUNCE_CNT`: the final forced assignment still guarantees `noisy`=`target`.
- Reset mid-sequence: all state returns to its reset value on the next edge. No `done` pulse is generated.

## Timing

- All outputs are registered. The response to a `level` change is 1 cycle: `noisy` takes the new value on the edge after `level` is sampled.
- With E = first BOUNCE cycle:
  - `busy` is high from E through E+ΣL−1.
  - `done` and `busy`=0 occur at cycle E+ΣL.
  - ΣL is the sum of `BOUNCE_CNT`+1 segment lengths.
- Number of `noisy` edges per sequence: `BOUNCE_CNT`+1 if `BOUNCE_CNT` is even, `BOUNCE_CNT`+2 if odd.
- A new sequence can start at the earliest on the cycle after `done`.

## Structure

- Package `bounce_pkg`:
  - state encoding (IDLE, BOUNCE);
  - `LFSR_TAPS`=16'hB400;
  - `TIMER_W`=20.
- Sub-module `lfsr16`, with ports `clk`, `reset`, `seed`, `q`. It holds the zero-seed substitution.
- Top-level `bounce_gen`: FSM, timer, and toggle counter. Target size is roughly 150–200 lines.

## Test plan

1. Reset with `level`=1 held: `noisy`=0, `busy`=0, `done`=0. On the first cycle after reset release, the sequence starts (`busy`=1 on the next edge).
2. Settings `MIN_LEN`=4, `LEN_MASK`=0, `BOUNCE_CNT`=4; drive `level` 0→1 (E = first BOUNCE cycle):
   - `noisy` = 1,0,1,0,1 in 4-cycle segments starting at E;
   - `done` at E+20, `busy` high E..E+19, then `noisy` stays 1.
3. Same parameters, `level` 1→0→1 during cycles E+2..E+6: the sequence is unchanged. At E+20 `noisy`=1, with no second sequence.
4. Settings `BOUNCE_CNT`=3, `MIN_LEN`=4, `LEN_MASK`=0: `noisy` = 1,0,1,0 in 4-cycle segments, forced to 1 at E+16 with `done`.
5. `bounce_en`=0; toggle `level` every 3 cycles: `noisy` equals `level` delayed by 1 cycle, with `busy`=0 throughout.
6. Loopback with default parameters into `debounce`; issue 4 level changes spaced 10 ms apart: `clean` makes exactly 4 transitions, and each occurs after that sequence's `done`.
